// File: rtl/pe_seq_ctrl_pkg.sv
// Shared constants for the PE sequencer: default widths, state encoding,
// and the number of drain cycles between the last read and FLUSH.
package pe_ctrl_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int SUM_W_DEF   = 36;
  localparam int ADDR_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int LEN_W       = ADDR_W_DEF + 1;

  // Read data lands on the operand registers two cycles after the strobe,
  // so FLUSH waits this many idle cycles after the final read.
  localparam int DRAIN_CYC   = 2;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_STREAM = 3'd1;
  localparam logic [ST_W-1:0] ST_FLUSH  = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLD   = 3'd4;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job request and result handshake between a host and the PE sequencer.
//
// Handshake semantics: the job request is a level 'start' sampled only while
// the sequencer is idle (no queuing, no ready). The result channel is strict
// valid/ready: res_valid rises once per job, res_sum is stable while
// res_valid is high, and the transfer completes on the rising clock edge
// where res_valid and res_ready are both high.
interface pe_seq_ctrl_if
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
);

  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] w_base;
  logic              res_valid;
  logic              res_ready;
  logic [SUM_W-1:0]  res_sum;

  modport master (
    output start, len, a_base, w_base, res_ready,
    input  res_valid, res_sum
  );

  modport slave (
    input  start, len, a_base, w_base, res_ready,
    output res_valid, res_sum
  );

endinterface

// File: rtl/pe_ctrl_timer.sv
// Enable-gated cycle counter for the WAIT state. It clears while 'clr' is
// high, counts while 'run' is high, and flags expiry on its last cycle.
module pe_ctrl_timer
  import pe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // Next count: clear wins, otherwise count up and saturate at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register; en=0 freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one systolic PE: streams two operand vectors from SRAM,
// marks end of vector, waits for the PE result and hands it downstream.
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  pe_seq_ctrl_if.slave      job,
  output logic              a_rd_en,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] w_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  input  logic [DATA_W-1:0] w_rd_data,
  output logic              pe_clr_n,
  output logic [DATA_W-1:0] pe_active,
  output logic [DATA_W-1:0] pe_weight,
  output logic              pe_input_done,
  input  logic              pe_calc_done,
  input  logic [SUM_W-1:0]  pe_sum,
  output logic              busy,
  output logic              err,
  output logic [ST_W-1:0]   dbg_state
);

  localparam int LN_W = ADDR_W + 1;
  localparam logic [LN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  logic [ST_W-1:0]   state_q, state_d;
  logic [LN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [LN_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic              clr_q, clr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] act_q, act_d;
  logic [DATA_W-1:0] wgt_q, wgt_d;
  logic [SUM_W-1:0]  res_sum_q, res_sum_d;
  logic              err_q, err_d;

  logic len_ok;
  logic rd_issue;
  logic tmr_expired;

  // A read is pending while streaming and fewer than len reads have gone out.
  assign len_ok   = (job.len != '0) && (job.len <= MAX_LEN);
  assign rd_issue = (state_q == ST_STREAM) && (rd_cnt_q != len_q);

  pe_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (state_q != ST_WAIT),
    .run     (state_q == ST_WAIT),
    .expired (tmr_expired)
  );

  // FSM, job latch, address/drain counters, read pipeline and result capture.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    a_base_d  = a_base_q;
    w_base_d  = w_base_q;
    rd_cnt_d  = rd_cnt_q;
    drain_d   = drain_q;
    clr_d     = 1'b0;
    res_sum_d = res_sum_q;
    err_d     = err_q;
    rd_vld_d  = rd_issue;
    act_d     = rd_vld_q ? a_rd_data : '0;
    wgt_d     = rd_vld_q ? w_rd_data : '0;
    case (state_q)
      ST_IDLE: begin
        if (job.start) begin
          if (len_ok) begin
            state_d  = ST_STREAM;
            len_d    = job.len;
            a_base_d = job.a_base;
            w_base_d = job.w_base;
            rd_cnt_d = '0;
            drain_d  = '0;
            clr_d    = 1'b1;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + LN_W'(1);
        end else if (drain_q == 2'(DRAIN_CYC - 1)) begin
          state_d = ST_FLUSH;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_FLUSH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (pe_calc_done) begin
          state_d   = ST_HOLD;
          res_sum_d = pe_sum;
        end else if (tmr_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (job.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; en=0 freezes everything including the read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      a_base_q  <= '0;
      w_base_q  <= '0;
      rd_cnt_q  <= '0;
      drain_q   <= '0;
      clr_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      act_q     <= '0;
      wgt_q     <= '0;
      res_sum_q <= '0;
      err_q     <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      len_q     <= len_d;
      a_base_q  <= a_base_d;
      w_base_q  <= w_base_d;
      rd_cnt_q  <= rd_cnt_d;
      drain_q   <= drain_d;
      clr_q     <= clr_d;
      rd_vld_q  <= rd_vld_d;
      act_q     <= act_d;
      wgt_q     <= wgt_d;
      res_sum_q <= res_sum_d;
      err_q     <= err_d;
    end
  end

  // Strobes are masked by en so a frozen cycle never issues a read or marker.
  assign a_rd_en       = rd_issue && en;
  assign w_rd_en       = rd_issue && en;
  assign a_rd_addr     = rd_issue ? (a_base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
  assign w_rd_addr     = rd_issue ? (w_base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
  assign pe_input_done = (state_q == ST_FLUSH) && en;
  assign pe_clr_n      = ~clr_q;
  assign pe_active     = act_q;
  assign pe_weight     = wgt_q;
  assign job.res_valid = (state_q == ST_HOLD);
  assign job.res_sum   = res_sum_q;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with SRAM and PE behavioural models and a
// queue-based scoreboard for read addresses and result sums.
module tb_pe_seq_ctrl;
  import pe_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int SW = 36;
  localparam int AW = 4;
  localparam int LW = LEN_W;
  localparam int TO = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          a_rd_en, w_rd_en;
  logic [AW-1:0] a_rd_addr, w_rd_addr;
  logic [DW-1:0] a_rd_data = '0;
  logic [DW-1:0] w_rd_data = '0;
  logic          pe_clr_n;
  logic [DW-1:0] pe_active, pe_weight;
  logic          pe_input_done;
  logic          pe_calc_done;
  logic [SW-1:0] pe_sum;
  logic          busy, err;
  logic [ST_W-1:0] dbg_state;

  pe_seq_ctrl_if #(.ADDR_W(AW), .SUM_W(SW)) job_if ();

  pe_seq_ctrl #(.DATA_W(DW), .SUM_W(SW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .job           (job_if),
    .a_rd_en       (a_rd_en),
    .w_rd_en       (w_rd_en),
    .a_rd_addr     (a_rd_addr),
    .w_rd_addr     (w_rd_addr),
    .a_rd_data     (a_rd_data),
    .w_rd_data     (w_rd_data),
    .pe_clr_n      (pe_clr_n),
    .pe_active     (pe_active),
    .pe_weight     (pe_weight),
    .pe_input_done (pe_input_done),
    .pe_calc_done  (pe_calc_done),
    .pe_sum        (pe_sum),
    .busy          (busy),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // SRAM model: 1-cycle read latency, data holds between reads
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_w [DEPTH];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (w_rd_en) w_rd_data <= mem_w[w_rd_addr];
  end

  // PE model: MAC on every enabled edge, done 3 cycles after input_done
  logic [SW-1:0] acc;
  logic [2:0]    dly;
  logic          pe_mute = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      dly <= '0;
    end else if (en) begin
      if (!pe_clr_n) acc <= '0;
      else           acc <= acc + SW'(pe_active) * SW'(pe_weight);
      if (pe_input_done)   dly <= 3'd3;
      else if (dly != '0)  dly <= dly - 3'd1;
    end
  end

  assign pe_calc_done = !pe_mute && (dly == 3'd1);
  assign pe_sum       = acc;

  // Scoreboard state
  logic [SW-1:0]   exp_q [$];
  logic [2*AW-1:0] addr_q [$];
  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor step, run at every falling edge
  task automatic mon_step();
    logic [2*AW-1:0] ae;
    logic [SW-1:0]   se;
    if (a_rd_en || w_rd_en) begin
      chk("a_rd_en_pair", 64'(a_rd_en), 64'd1);
      chk("w_rd_en_pair", 64'(w_rd_en), 64'd1);
      chk("rd_expected", 64'(addr_q.size() != 0), 64'd1);
      if (addr_q.size() != 0) begin
        ae = addr_q.pop_front();
        chk("rd_addr", 64'({a_rd_addr, w_rd_addr}), 64'(ae));
      end
    end
    if (job_if.res_valid) valid_cnt++;
    if (job_if.res_valid && job_if.res_ready && en) begin
      chk("res_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        se = exp_q.pop_front();
        chk("res_sum_sb", 64'(job_if.res_sum), 64'(se));
      end
    end
  endtask

  // Driver: push expectations, then present the job for one edge and scramble inputs
  task automatic start_job(input int l, input int ab, input int wb, input bit expect_res);
    logic [SW-1:0] s;
    logic [AW-1:0] av, wv;
    s = '0;
    for (int i = 0; i < l; i++) begin
      av = AW'((ab + i) % DEPTH);
      wv = AW'((wb + i) % DEPTH);
      addr_q.push_back({av, wv});
      s = s + SW'(mem_a[av]) * SW'(mem_w[wv]);
    end
    if (expect_res) exp_q.push_back(s);
    job_if.start  = 1'b1;
    job_if.len    = LW'(l);
    job_if.a_base = AW'(ab);
    job_if.w_base = AW'(wb);
    cyc();
    job_if.start  = 1'b0;
    job_if.len    = LW'($urandom_range(0, 31));
    job_if.a_base = AW'($urandom_range(0, DEPTH - 1));
    job_if.w_base = AW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!job_if.res_valid && n < limit) begin
      cyc();
      n++;
    end
    chk("res_valid_seen", 64'(job_if.res_valid), 64'd1);
  endtask

  // Directed sequence
  initial begin
    int n;
    int v0;
    logic [DW-1:0] exp_act [4];
    logic [DW-1:0] exp_wgt [4];
    exp_act = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_wgt = '{16'd5, 16'd6, 16'd7, 16'd8};

    job_if.start     = 1'b0;
    job_if.len       = '0;
    job_if.a_base    = '0;
    job_if.w_base    = '0;
    job_if.res_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom_range(0, 16'hffff));
      mem_w[i] = DW'($urandom_range(0, 16'hffff));
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = exp_act[i];
      mem_w[i] = exp_wgt[i];
    end

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset state
    repeat (3) cyc();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clr_n", 64'(pe_clr_n), 64'd1);
    chk("rst_rd_en", 64'(a_rd_en), 64'd0);
    chk("rst_active", 64'(pe_active), 64'd0);
    chk("rst_valid", 64'(job_if.res_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    cyc();

    // len=0 is rejected with err and no reads
    job_if.start = 1'b1;
    job_if.len   = '0;
    cyc();
    job_if.start = 1'b0;
    chk("len0_err", 64'(err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    cyc();
    chk("len0_still_idle", 64'(busy), 64'd0);

    // Basic job with result backpressure
    job_if.res_ready = 1'b0;
    start_job(4, 0, 0, 1'b1);
    chk("basic_err_cleared", 64'(err), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("clr_n_c%0d", k), 64'(pe_clr_n), 64'((k == 1) ? 0 : 1));
      chk($sformatf("rd_en_c%0d", k), 64'(a_rd_en), 64'((k <= 4) ? 1 : 0));
      chk($sformatf("active_c%0d", k), 64'(pe_active),
          64'((k >= 3 && k <= 6) ? exp_act[(k - 3) % 4] : 16'd0));
      chk($sformatf("weight_c%0d", k), 64'(pe_weight),
          64'((k >= 3 && k <= 6) ? exp_wgt[(k - 3) % 4] : 16'd0));
      chk($sformatf("input_done_c%0d", k), 64'(pe_input_done), 64'((k == 7) ? 1 : 0));
      cyc();
    end
    wait_valid(20);
    for (int k = 0; k < 5; k++) begin
      job_if.start = (k == 2);
      job_if.len   = LW'(2);
      @(negedge clk);
      chk("bp_valid", 64'(job_if.res_valid), 64'd1);
      chk("bp_sum", 64'(job_if.res_sum), 64'h46);
      chk("bp_busy", 64'(busy), 64'd1);
      cyc();
    end
    job_if.start     = 1'b0;
    job_if.res_ready = 1'b1;
    cyc();
    chk("hs_idle", 64'(busy), 64'd0);
    chk("hs_valid_low", 64'(job_if.res_valid), 64'd0);

    // Address wrap, started in the cycle right after the handshake
    start_job(4, 14, 3, 1'b1);
    chk("wrap_busy", 64'(busy), 64'd1);
    wait_valid(30);
    cyc();
    chk("wrap_idle", 64'(busy), 64'd0);

    // Full depth
    start_job(DEPTH, 7, 9, 1'b1);
    wait_valid(40);
    cyc();
    chk("full_idle", 64'(busy), 64'd0);

    // PE never answers: timeout
    pe_mute = 1'b1;
    v0 = valid_cnt;
    start_job(2, 5, 5, 1'b0);
    n = 1;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    chk("timeout_cycle", 64'(n), 64'(2 + 4 + TO));
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_no_valid", 64'(valid_cnt - v0), 64'd0);
    pe_mute = 1'b0;

    // Enable gap mid-stream; start also clears err
    start_job(4, 0, 0, 1'b1);
    chk("en_err_cleared", 64'(err), 64'd0);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("gap_a_rd_en", 64'(a_rd_en), 64'd0);
      chk("gap_w_rd_en", 64'(w_rd_en), 64'd0);
      chk("gap_input_done", 64'(pe_input_done), 64'd0);
      chk("gap_state", 64'(dbg_state), 64'(ST_STREAM));
      cyc();
    end
    en = 1'b1;
    wait_valid(40);
    chk("gap_sum", 64'(job_if.res_sum), 64'h46);
    cyc();
    chk("gap_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-stream
    start_job(8, 0, 0, 1'b0);
    cyc();
    cyc();
    chk("pre_rst_active", 64'(pe_active), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("arst_rd_en", 64'({a_rd_en, w_rd_en}), 64'd0);
    chk("arst_addr", 64'({a_rd_addr, w_rd_addr}), 64'd0);
    chk("arst_clr_n", 64'(pe_clr_n), 64'd1);
    chk("arst_operands", 64'({pe_active, pe_weight}), 64'd0);
    chk("arst_input_done", 64'(pe_input_done), 64'd0);
    chk("arst_valid", 64'(job_if.res_valid), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    addr_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 64'(busy), 64'd0);

    // Everything expected was observed
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("addr_q_drained", 64'(addr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
